// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: state encoding,
// direction codes and the reverse-direction helper.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_FLASH = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Opposite directions differ only in bit 0 (up<->down, left<->right).
  function automatic logic [1:0] reverseDir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Programmable-period divider: counts 0..period-1 while enabled and not held,
// flags the wrap cycle combinationally; clear has priority over counting.
module snake_tick_div
  import snake_pkg::*;
#(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] count;
  logic             advance;

  assign advance = en & ~hold;
  // >= rather than == so a period shortened below the current count still wraps.
  assign wrap = advance && (count >= period - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move-tick timing, run/pause/game-over FSM, direction
// latch and game-over flash. Optional SNAKE_SPEEDUP_EN shortens the tick per fruit.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV    = 4000000,
  parameter int FLASH_HALF  = 2000000,
  parameter int FLASH_COUNT = 4,
  parameter int CNT_W       = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       dir_valid,
  input  logic [1:0] dir_in,
  input  logic       collision,
  input  logic       fruit_eaten,
  output logic       move_tick,
  output logic [3:0] move_dir,
  output logic       clear_game,
  output logic       paused,
  output logic       game_over,
  output logic       flash_blue,
  output logic [2:0] state_dbg
);

  localparam int PCW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  state_t           state, stateNext;
  logic             startPrev, pausePrev;
  logic             startEdge, pauseEdge;
  logic             restart, colHit, flashDone;
  logic             moveWrap, flashWrap;
  logic             moveTick, moveTickD, clearGame;
  logic [1:0]       moveDir, pendDir;
  logic             flashPhase;
  logic [PCW-1:0]   flashPeriods;
  logic [CNT_W-1:0] activePeriod;

  assign startEdge = start_btn & ~startPrev;
  assign pauseEdge = pause_btn & ~pausePrev;
  // Start beats pause beats collision; FLASH ignores both buttons.
  assign restart   = startEdge && (state != ST_FLASH);
  assign colHit    = (state == ST_RUN) && moveTickD && collision && !startEdge && !pauseEdge;
  assign flashDone = (state == ST_FLASH) && flashWrap && flashPhase &&
                     (flashPeriods == PCW'(FLASH_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (startEdge) stateNext = ST_RUN;
      ST_RUN: begin
        if (startEdge)      stateNext = ST_RUN;
        else if (pauseEdge) stateNext = ST_PAUSE;
        else if (colHit)    stateNext = ST_FLASH;
      end
      ST_PAUSE: if (startEdge || pauseEdge) stateNext = ST_RUN;
      ST_FLASH: if (flashDone) stateNext = ST_OVER;
      ST_OVER:  if (startEdge) stateNext = ST_RUN;
      default:  stateNext = ST_IDLE;
    endcase
  end

  snake_tick_div #(.CNT_W(CNT_W)) uMoveDiv (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .en     (state == ST_RUN),
    .hold   (startEdge | pauseEdge | colHit),
    .period (activePeriod),
    .wrap   (moveWrap)
  );

  snake_tick_div #(.CNT_W(CNT_W)) uFlashDiv (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_FLASH),
    .en     (state == ST_FLASH),
    .hold   (1'b0),
    .period (CNT_W'(FLASH_HALF)),
    .wrap   (flashWrap)
  );

  // dir_valid/dir_in: no backpressure; a request is taken in the cycle it is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      startPrev    <= 1'b0;
      pausePrev    <= 1'b0;
      moveTick     <= 1'b0;
      moveTickD    <= 1'b0;
      clearGame    <= 1'b0;
      moveDir      <= DIR_RIGHT;
      pendDir      <= DIR_RIGHT;
      flashPhase   <= 1'b0;
      flashPeriods <= '0;
    end else begin
      startPrev <= start_btn;
      pausePrev <= pause_btn;
      moveTick  <= moveWrap;
      moveTickD <= moveTick;
      clearGame <= restart;
      if (restart) begin
        moveDir <= DIR_RIGHT;
        pendDir <= DIR_RIGHT;
      end else begin
        if (moveWrap) moveDir <= pendDir;
        if (dir_valid && (dir_in != reverseDir(moveDir))) pendDir <= dir_in;
      end
      if (state != ST_FLASH) begin
        flashPhase   <= 1'b0;
        flashPeriods <= '0;
      end else if (flashWrap) begin
        flashPhase <= ~flashPhase;
        if (flashPhase) flashPeriods <= flashDone ? '0 : flashPeriods + 1'b1;
      end
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PERIOD_FULL  = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] PERIOD_STEP  = CNT_W'(TICK_DIV / 16);
  localparam logic [CNT_W-1:0] PERIOD_FLOOR = CNT_W'(TICK_DIV / 4);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      activePeriod <= PERIOD_FULL;
    end else if (fruit_eaten && !colHit) begin
      activePeriod <= (activePeriod >= PERIOD_FLOOR + PERIOD_STEP) ?
                      activePeriod - PERIOD_STEP : PERIOD_FLOOR;
    end
  end
`else
  logic unusedFruit;
  assign unusedFruit  = fruit_eaten;
  assign activePeriod = CNT_W'(TICK_DIV);
`endif

  assign move_tick  = moveTick;
  assign move_dir   = {2'b00, moveDir};
  assign clear_game = clearGame;
  assign paused     = (state == ST_PAUSE);
  assign game_over  = (state == ST_FLASH) || (state == ST_OVER);
  assign flash_blue = flashPhase;
  assign state_dbg  = state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: vector table, directed corner sequences and
// random traffic against a cycle-level game model.
module tb_snake_game_ctrl;
  import snake_pkg::*;

`ifdef SNAKE_SPEEDUP_EN
  localparam int TD = 64;
`else
  localparam int TD = 8;
`endif
  localparam int FH = 4;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int NB = 2 * FH * FC;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FLASH = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       reset, start_btn, pause_btn, dir_valid, collision, fruit_eaten;
  logic [1:0] dir_in;
  logic       move_tick, clear_game, paused, game_over, flash_blue;
  logic [3:0] move_dir;
  logic [2:0] state_dbg;

  snake_game_ctrl #(.TICK_DIV(TD), .FLASH_HALF(FH), .FLASH_COUNT(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .dir_valid(dir_valid), .dir_in(dir_in), .collision(collision),
    .fruit_eaten(fruit_eaten), .move_tick(move_tick), .move_dir(move_dir),
    .clear_game(clear_game), .paused(paused), .game_over(game_over),
    .flash_blue(flash_blue), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of the game
  int mState, mDir, mPend, mSince, mPeriod, mFlashT;
  bit mTick, mTickD, mClear, mPrevS, mPrevP;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    mState = M_IDLE; mDir = 3; mPend = 3; mSince = 0; mPeriod = TD; mFlashT = 0;
    mTick = 0; mTickD = 0; mClear = 0; mPrevS = 0; mPrevP = 0;
  endtask

  task automatic model_step();
    bit sE, pE, nTick, nClear, hit;
    int oldDir;
    if (reset) begin
      model_reset();
      return;
    end
    sE = start_btn && !mPrevS;
    pE = pause_btn && !mPrevP;
    mPrevS = start_btn;
    mPrevP = pause_btn;
    nTick = 0; nClear = 0; hit = 0; oldDir = mDir;
    if (sE && mState != M_FLASH) begin
      mState = M_RUN; mDir = 3; mPend = 3; mSince = 0; mPeriod = TD; nClear = 1;
    end else begin
      case (mState)
        M_RUN: begin
          if (pE) mState = M_PAUSE;
          else if (mTickD && collision) begin
            hit = 1; mState = M_FLASH; mFlashT = 0;
          end else begin
            mSince++;
            if (mSince >= mPeriod) begin
              mSince = 0; nTick = 1; mDir = mPend;
            end
          end
        end
        M_PAUSE: if (pE) mState = M_RUN;
        M_FLASH: begin
          mFlashT++;
          if (mFlashT == NB) mState = M_OVER;
        end
        default: ;
      endcase
      if (dir_valid && int'(dir_in) != opposite(oldDir)) mPend = int'(dir_in);
`ifdef SNAKE_SPEEDUP_EN
      if (fruit_eaten && !hit)
        mPeriod = (mPeriod - TD / 16 < TD / 4) ? TD / 4 : mPeriod - TD / 16;
`endif
    end
    mTickD = mTick;
    mTick  = nTick;
    mClear = nClear;
  endtask

  // scoreboard
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver: one clock with the current inputs, then compare against the model
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("move_tick", int'(move_tick), int'(mTick));
    check("move_dir", int'(move_dir), mDir);
    check("clear_game", int'(clear_game), int'(mClear));
    check("paused", int'(paused), int'(mState == M_PAUSE));
    check("game_over", int'(game_over), int'(mState == M_FLASH || mState == M_OVER));
    check("flash_blue", int'(flash_blue),
          int'(mState == M_FLASH && ((mFlashT / FH) % 2) == 1));
    check("tick_clear_excl", int'(move_tick & clear_game), 0);
  endtask

  task automatic idle_inputs();
    reset = 0; start_btn = 0; pause_btn = 0; dir_valid = 0; dir_in = 0;
    collision = 0; fruit_eaten = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic press_start();
    start_btn = 1; cyc(); start_btn = 0;
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 4 * TD + 8; i++) begin
      cyc();
      if (move_tick) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    bit       s, p, dv;
    bit [1:0] di;
    bit       eTick;
    int       eDir;
    bit       eClr, ePaused, eOver, eBlue;
  } vec_t;

  vec_t vecs[10];
  logic [NB-1:0] gotPat, expPat;
  int n, ticks, want;

  initial begin
    // s  p  dv di  tick dir clr paused over blue
    vecs[0] = '{0, 0, 0, 2'd0, 0, 3, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 2'd0, 0, 3, 1, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 2'd0, 0, 3, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 2'd2, 0, 3, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 2'd0, 0, 3, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 1, 2'd1, 0, 3, 0, 0, 0, 0};
    vecs[6] = '{0, 1, 0, 2'd0, 0, 3, 0, 1, 0, 0};
    vecs[7] = '{0, 1, 0, 2'd0, 0, 3, 0, 1, 0, 0};
    vecs[8] = '{0, 0, 0, 2'd0, 0, 3, 0, 1, 0, 0};
    vecs[9] = '{0, 1, 0, 2'd0, 0, 3, 0, 0, 0, 0};

    model_reset();
    do_reset();
    check("rst_state", int'(state_dbg), int'(ST_IDLE));
    check("rst_dir", int'(move_dir), 3);

    foreach (vecs[i]) begin
      start_btn = vecs[i].s; pause_btn = vecs[i].p;
      dir_valid = vecs[i].dv; dir_in = vecs[i].di;
      cyc();
      check($sformatf("vec%0d_tick", i), int'(move_tick), int'(vecs[i].eTick));
      check($sformatf("vec%0d_dir", i), int'(move_dir), vecs[i].eDir);
      check($sformatf("vec%0d_clr", i), int'(clear_game), int'(vecs[i].eClr));
      check($sformatf("vec%0d_paused", i), int'(paused), int'(vecs[i].ePaused));
      check($sformatf("vec%0d_over", i), int'(game_over), int'(vecs[i].eOver));
      check($sformatf("vec%0d_blue", i), int'(flash_blue), int'(vecs[i].eBlue));
    end
    idle_inputs();
    // count was frozen at 4 across the pause; last request (down) wins at the tick
    wait_tick(n);
    check("resume_tick_gap", n, TD - 4);
    check("dir_at_tick", int'(move_dir), 1);

    // start -> clear pulse, then ticks every TD
    do_reset();
    press_start();
    check("start_clear", int'(clear_game), 1);
    wait_tick(n);
    check("first_tick_gap", n, TD);
    wait_tick(n);
    check("tick_gap", n, TD);
    check("dir_right", int'(move_dir), 3);

    // reversal rejection against committed direction
    dir_valid = 1; dir_in = 2'd1; cyc(); dir_valid = 0;
    wait_tick(n);
    check("dir_down", int'(move_dir), 1);
    dir_valid = 1; dir_in = 2'd0; cyc(); dir_valid = 0;
    wait_tick(n);
    check("reverse_ignored", int'(move_dir), 1);
    dir_valid = 1; dir_in = 2'd2; cyc(); dir_in = 2'd0; cyc(); dir_valid = 0;
    wait_tick(n);
    check("reverse_vs_committed", int'(move_dir), 2);

    // pause at count 5, 50 frozen cycles, resume
    for (int i = 0; i < 5; i++) cyc();
    pause_btn = 1; cyc(); pause_btn = 0;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (move_tick) ticks++;
    end
    check("pause_no_ticks", ticks, 0);
    pause_btn = 1; cyc(); pause_btn = 0;
    wait_tick(n);
    check("pause_resume_gap", n, TD - 5);

    // collision one cycle after a tick -> flash pattern -> OVER
    wait_tick(n);
    cyc();
    collision = 1; cyc(); collision = 0;
    check("collide_over", int'(game_over), 1);
    gotPat[0] = flash_blue;
    for (int i = 1; i < NB; i++) begin
      pause_btn = (i == 5);
      cyc();
      gotPat[i] = flash_blue;
    end
    pause_btn = 0;
    for (int i = 0; i < NB; i++) expPat[i] = ((i / FH) % 2) == 1;
    check("flash_pattern", int'(gotPat), int'(expPat));
    cyc();
    check("over_state", int'(state_dbg), int'(ST_OVER));
    check("over_blue", int'(flash_blue), 0);
    check("over_game_over", int'(game_over), 1);

    // start and pause together in OVER: restart wins
    start_btn = 1; pause_btn = 1; cyc();
    check("restart_clear", int'(clear_game), 1);
    check("restart_paused", int'(paused), 0);
    check("restart_state", int'(state_dbg), int'(ST_RUN));
    idle_inputs();
    cyc();

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 799) == 0);
      start_btn   = ($urandom_range(0, 249) == 0);
      pause_btn   = ($urandom_range(0, 69) == 0);
      dir_valid   = ($urandom_range(0, 5) == 0);
      dir_in      = 2'($urandom_range(0, 3));
      collision   = ($urandom_range(0, 29) == 0);
      fruit_eaten = ($urandom_range(0, 9) == 0);
      cyc();
    end
    idle_inputs();

`ifdef SNAKE_SPEEDUP_EN
    do_reset();
    press_start();
    wait_tick(n);
    check("speed_base", n, TD);
    for (int k = 1; k <= 20; k++) begin
      fruit_eaten = 1; cyc(); fruit_eaten = 0;
      wait_tick(n);
      want = TD - (TD / 16) * k;
      if (want < TD / 4) want = TD / 4;
      check($sformatf("speed_gap%0d", k), (n < 0) ? n : n + 1, want);
    end
    press_start();
    wait_tick(n);
    check("speed_restored", n, TD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
